// File: rtl/dmi_req_fifo.sv
// rtl/dmi_req_fifo.sv - DMI request queue between the DTM and the Debug Module
module dmi_req_fifo #(
    parameter int Depth     = 2,
    parameter int AddrWidth = 7,
    parameter int DataWidth = 32,
    localparam int CntW     = $clog2(Depth + 1),
    localparam int PtrW     = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dmi_rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [1:0]           req_op_i,
    input  logic [DataWidth-1:0] req_data_i,
    output logic                 dm_valid_o,
    input  logic                 dm_ready_i,
    output logic [AddrWidth-1:0] dm_addr_o,
    output logic [1:0]           dm_op_o,
    output logic [DataWidth-1:0] dm_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CntW-1:0]      count_o,
    output logic                 overflow_o
);
    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [1:0]           op;
        logic [DataWidth-1:0] data;
    } entry_t;

    entry_t          mem_q [Depth];
    entry_t          mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            rw_op, full, empty, push, pop;
    entry_t          head;

    // Explicit wrap so non-power-of-two depths never address past the array.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign rw_op = req_valid_i && ((req_op_i == 2'd1) || (req_op_i == 2'd2));
    assign push  = rw_op && !full;
    assign pop   = dm_ready_i && !empty;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (!dmi_rst_ni) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {req_addr_i, req_op_i, req_data_i};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (rw_op && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; stale contents are masked at the outputs.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign dm_addr_o   = empty ? '0 : head.addr;
    assign dm_op_o     = empty ? '0 : head.op;
    assign dm_data_o   = empty ? '0 : head.data;
    assign dm_valid_o  = !empty;
    assign req_ready_o = !full;
    assign full_o      = full;
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_dmi_req_fifo.sv
// tb/tb_dmi_req_fifo.sv - randomized model-checked bench for dmi_req_fifo (Depth 2 and 3)
module tb_dmi_req_fifo;
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmi_rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [1:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic        dm_ready = 1'b0;

    logic [1:0]  rdy_o, val_o, full_o, empty_o, ovf_o;
    logic [6:0]  addr_o [2];
    logic [1:0]  op_o   [2];
    logic [31:0] data_o [2];
    logic [1:0]  cnt_o  [2];

    int n_pass = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    entry_t mq [2][$];
    bit     movf [2];

    always #5 clk = ~clk;

    dmi_req_fifo #(.Depth(2), .AddrWidth(7), .DataWidth(32)) u_d2 (
        .clk_i(clk), .rst_i(rst), .dmi_rst_ni(dmi_rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy_o[0]), .req_addr_i(req_addr),
        .req_op_i(req_op), .req_data_i(req_data),
        .dm_valid_o(val_o[0]), .dm_ready_i(dm_ready), .dm_addr_o(addr_o[0]),
        .dm_op_o(op_o[0]), .dm_data_o(data_o[0]),
        .full_o(full_o[0]), .empty_o(empty_o[0]), .count_o(cnt_o[0]), .overflow_o(ovf_o[0])
    );

    dmi_req_fifo #(.Depth(3), .AddrWidth(7), .DataWidth(32)) u_d3 (
        .clk_i(clk), .rst_i(rst), .dmi_rst_ni(dmi_rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy_o[1]), .req_addr_i(req_addr),
        .req_op_i(req_op), .req_data_i(req_data),
        .dm_valid_o(val_o[1]), .dm_ready_i(dm_ready), .dm_addr_o(addr_o[1]),
        .dm_op_o(op_o[1]), .dm_data_o(data_o[1]),
        .full_o(full_o[1]), .empty_o(empty_o[1]), .count_o(cnt_o[1]), .overflow_o(ovf_o[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference: a plain queue per instance, updated on each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  depth;
            bit  rw, is_full, is_empty;
            depth = (k == 0) ? 2 : 3;
            if (rst || !dmi_rst_n) begin
                mq[k].delete();
                movf[k] = 1'b0;
            end else begin
                rw       = req_valid && (req_op == 2'd1 || req_op == 2'd2);
                is_full  = (mq[k].size() == depth);
                is_empty = (mq[k].size() == 0);
                if (rw && is_full) movf[k] = 1'b1;
                if (dm_ready && !is_empty) void'(mq[k].pop_front());
                if (rw && !is_full) mq[k].push_back({req_addr, req_op, req_data});
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                int     depth, sz;
                entry_t h;
                depth = (k == 0) ? 2 : 3;
                sz    = mq[k].size();
                h     = (sz == 0) ? '0 : mq[k][0];
                chk($sformatf("d%0d_count", depth), 64'(cnt_o[k]), 64'(sz));
                chk($sformatf("d%0d_full", depth), 64'(full_o[k]), 64'(sz == depth));
                chk($sformatf("d%0d_empty", depth), 64'(empty_o[k]), 64'(sz == 0));
                chk($sformatf("d%0d_ready", depth), 64'(rdy_o[k]), 64'(sz != depth));
                chk($sformatf("d%0d_valid", depth), 64'(val_o[k]), 64'(sz != 0));
                chk($sformatf("d%0d_addr", depth), 64'(addr_o[k]), 64'(h.addr));
                chk($sformatf("d%0d_op", depth), 64'(op_o[k]), 64'(h.op));
                chk($sformatf("d%0d_data", depth), 64'(data_o[k]), 64'(h.data));
                chk($sformatf("d%0d_ovf", depth), 64'(ovf_o[k]), 64'(movf[k]));
            end
        end
    end

    task automatic cyc(input logic v, input logic [1:0] op, input logic [6:0] a,
                       input logic [31:0] d, input logic r);
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        dm_ready  = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        check_en = 1'b1;
        #1;
        chk("rst_count", 64'(cnt_o[0]), 0);
        chk("rst_empty", 64'(empty_o[0]), 1);
        chk("rst_ready", 64'(rdy_o[0]), 1);
        chk("rst_valid", 64'(val_o[0]), 0);
        chk("rst_ovf", 64'(ovf_o[0]), 0);

        cyc(1, 1, 7'h10, 32'hA5A5A5A5, 0);
        chk("rd_valid", 64'(val_o[0]), 1);
        chk("rd_op", 64'(op_o[0]), 1);
        chk("rd_addr", 64'(addr_o[0]), 64'h10);
        chk("rd_count", 64'(cnt_o[0]), 1);
        cyc(0, 0, 0, 0, 1);
        chk("pop_empty", 64'(empty_o[0]), 1);
        chk("pop_addr_zero", 64'(addr_o[0]), 0);
        chk("pop_data_zero", 64'(data_o[0]), 0);

        cyc(1, 2, 7'h04, 32'hDEADBEEF, 0);
        cyc(1, 2, 7'h05, 32'h12345678, 0);
        chk("fill_full", 64'(full_o[0]), 1);
        chk("fill_ready", 64'(rdy_o[0]), 0);
        chk("fill_head_addr", 64'(addr_o[0]), 64'h04);
        chk("fill_head_data", 64'(data_o[0]), 64'hDEADBEEF);

        cyc(1, 1, 7'h11, 32'h0, 0);
        chk("drop_ovf", 64'(ovf_o[0]), 1);
        chk("drop_count", 64'(cnt_o[0]), 2);
        chk("d3_accept_count", 64'(cnt_o[1]), 3);
        chk("d3_accept_ovf", 64'(ovf_o[1]), 0);
        cyc(0, 0, 0, 0, 1);
        chk("pop2_addr", 64'(addr_o[0]), 64'h05);
        chk("pop2_data", 64'(data_o[0]), 64'h12345678);
        cyc(0, 0, 0, 0, 1);
        chk("d3_tail_addr", 64'(addr_o[1]), 64'h11);
        cyc(0, 0, 0, 0, 1);
        chk("drain_ovf_sticky", 64'(ovf_o[0]), 1);
        chk("drain_empty", 64'(empty_o[0]), 1);

        dmi_rst_n = 1'b0;
        cyc(1, 1, 7'h22, 32'h1, 1);
        dmi_rst_n = 1'b1;
        chk("flush_ovf", 64'(ovf_o[0]), 0);
        chk("flush_count", 64'(cnt_o[0]), 0);

        cyc(1, 0, 7'h40, 32'h2, 0);
        chk("nop_count", 64'(cnt_o[0]), 0);
        cyc(1, 3, 7'h41, 32'h3, 0);
        chk("rsv_count", 64'(cnt_o[0]), 0);
        chk("rsv_ovf", 64'(ovf_o[0]), 0);
        chk("rsv_valid", 64'(val_o[0]), 0);

        cyc(1, 1, 7'h30, 32'h4, 0);
        cyc(1, 2, 7'h31, 32'hCAFEF00D, 1);
        chk("pp_count", 64'(cnt_o[0]), 1);
        chk("pp_head_addr", 64'(addr_o[0]), 64'h31);
        chk("pp_head_data", 64'(data_o[0]), 64'hCAFEF00D);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 7'h32, 32'h5, 1);
        chk("pp_empty_count", 64'(cnt_o[0]), 1);
        chk("pp_empty_addr", 64'(addr_o[0]), 64'h32);

        cyc(1, 2, 7'h33, 32'h6, 0);
        cyc(1, 1, 7'h34, 32'h7, 1);
        chk("fullpp_count", 64'(cnt_o[0]), 1);
        chk("fullpp_ovf", 64'(ovf_o[0]), 1);
        chk("fullpp_head", 64'(addr_o[0]), 64'h33);
        dmi_rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0);
        dmi_rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            cyc(i % 2 == 0, 2'(1 + (i / 2) % 2), 7'(i), $urandom, i % 2 == 1);
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1, 2'(1 + i % 2), 7'(i + 64), $urandom, 1);
        end

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            dmi_rst_n = ($urandom_range(0, 59) != 0);
            cyc($urandom_range(0, 99) < 65, 2'($urandom_range(0, 3)),
                7'($urandom_range(0, 127)), $urandom, $urandom_range(0, 99) < 45);
        end
        rst = 1'b0;
        dmi_rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
